// File: rtl/vdp_cpu_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_cpu_port_if
//  Description : Z80 I/O strobes and VRAM CPU-port signals of the VDP front end.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vdp_cpu_port_if;
    logic        io_wr;
    logic        io_rd;
    logic        port;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic [13:0] vga_addr;
    logic [7:0]  vga_din;
    logic        vga_wr;
    logic        vga_rd;
    logic [7:0]  vga_dout;

    // The master side is the environment: CPU strobes and VRAM read data.
    modport master (
        output io_wr, io_rd, port, cpu_din, vga_dout,
        input  cpu_dout, vga_addr, vga_din, vga_wr, vga_rd
    );

    modport slave (
        input  io_wr, io_rd, port, cpu_din, vga_dout,
        output cpu_dout, vga_addr, vga_din, vga_wr, vga_rd
    );
endinterface
`default_nettype wire

// File: rtl/vdp_cpu_port.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_cpu_port
//  Description : MSX VDP CPU front end - ports 0x98/0x99, R0-R7, status latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module vdp_cpu_port (
    input  wire logic        clk,
    input  wire logic        n_reset,
    vdp_cpu_port_if.slave    bus,
    output logic [1:0]       mode,
    output logic             video_on,
    output logic             vert_retrace_int,
    output logic             sprite_large,
    output logic             sprite_enlarged,
    output logic [13:0]      name_table_addr,
    output logic [13:0]      color_table_addr,
    output logic [13:0]      font_addr,
    output logic [13:0]      sprite_attr_addr,
    output logic [13:0]      sprite_pattern_table_addr,
    output logic [3:0]       text_color,
    output logic [3:0]       back_color,
    input  wire logic        interrupt_flag,
    input  wire logic        sprite_collision,
    input  wire logic        too_many_sprites,
    input  wire logic [4:0]  sprite5
);

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_RD   = 2'd1,
        PF_WAIT = 2'd2
    } pf_state_t;

    ctrl_state_t      ctrl_q, ctrl_d;
    pf_state_t        pf_q, pf_d;
    logic [7:0]       latch_q, latch_d;
    logic [7:0][7:0]  regs_q, regs_d;
    logic [13:0]      addr_q, addr_d;
    logic [7:0]       read_buf_q, read_buf_d;
    logic [7:0]       cpu_dout_q, cpu_dout_d;
    logic [13:0]      vga_addr_q, vga_addr_d;
    logic [7:0]       vga_din_q, vga_din_d;
    logic             vga_wr_q, vga_wr_d;
    logic             vga_rd_q, vga_rd_d;
    logic             f_q, f_d;
    logic             c_q, c_d;
    logic             fs_q, fs_d;
    logic [4:0]       s5_q, s5_d;
    logic             int_prev_q, int_prev_d;
    logic             hold_v_q, hold_v_d;
    logic             hold_wr_q, hold_wr_d;
    logic             hold_port_q, hold_port_d;
    logic [7:0]       hold_din_q, hold_din_d;

    logic             f_set;
    logic             new_vld;
    logic             do_v;
    logic             do_wr;
    logic             do_port;
    logic [7:0]       do_din;
    logic             mode2;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ctrl_q      <= ST_FIRST;
            pf_q        <= PF_IDLE;
            latch_q     <= '0;
            regs_q      <= '0;
            addr_q      <= '0;
            read_buf_q  <= '0;
            cpu_dout_q  <= '0;
            vga_addr_q  <= '0;
            vga_din_q   <= '0;
            vga_wr_q    <= 1'b0;
            vga_rd_q    <= 1'b0;
            f_q         <= 1'b0;
            c_q         <= 1'b0;
            fs_q        <= 1'b0;
            s5_q        <= '0;
            int_prev_q  <= 1'b0;
            hold_v_q    <= 1'b0;
            hold_wr_q   <= 1'b0;
            hold_port_q <= 1'b0;
            hold_din_q  <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            pf_q        <= pf_d;
            latch_q     <= latch_d;
            regs_q      <= regs_d;
            addr_q      <= addr_d;
            read_buf_q  <= read_buf_d;
            cpu_dout_q  <= cpu_dout_d;
            vga_addr_q  <= vga_addr_d;
            vga_din_q   <= vga_din_d;
            vga_wr_q    <= vga_wr_d;
            vga_rd_q    <= vga_rd_d;
            f_q         <= f_d;
            c_q         <= c_d;
            fs_q        <= fs_d;
            s5_q        <= s5_d;
            int_prev_q  <= int_prev_d;
            hold_v_q    <= hold_v_d;
            hold_wr_q   <= hold_wr_d;
            hold_port_q <= hold_port_d;
            hold_din_q  <= hold_din_d;
        end
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        pf_d        = pf_q;
        latch_d     = latch_q;
        regs_d      = regs_q;
        addr_d      = addr_q;
        read_buf_d  = read_buf_q;
        cpu_dout_d  = cpu_dout_q;
        vga_addr_d  = vga_addr_q;
        vga_din_d   = vga_din_q;
        vga_wr_d    = 1'b0;
        vga_rd_d    = 1'b0;
        hold_v_d    = hold_v_q;
        hold_wr_d   = hold_wr_q;
        hold_port_d = hold_port_q;
        hold_din_d  = hold_din_q;
        do_v        = 1'b0;
        do_wr       = 1'b0;
        do_port     = 1'b0;
        do_din      = '0;

        f_set      = interrupt_flag & ~int_prev_q;
        int_prev_d = interrupt_flag;
        f_d        = f_q  | f_set;
        c_d        = c_q  | sprite_collision;
        fs_d       = fs_q | too_many_sprites;
        s5_d       = fs_q ? s5_q : sprite5;

        new_vld = bus.io_wr | bus.io_rd;

        case (pf_q)
            PF_RD:   pf_d = PF_WAIT;
            PF_WAIT: begin
                read_buf_d = bus.vga_dout;
                addr_d     = addr_q + 14'd1;
                pf_d       = PF_IDLE;
            end
            default: pf_d = pf_q;
        endcase

        // A strobe seen while a prefetch is in flight waits in the hold slot.
        if (pf_q == PF_IDLE) begin
            if (hold_v_q) begin
                do_v        = 1'b1;
                do_wr       = hold_wr_q;
                do_port     = hold_port_q;
                do_din      = hold_din_q;
                hold_v_d    = new_vld;
                hold_wr_d   = bus.io_wr;
                hold_port_d = bus.port;
                hold_din_d  = bus.cpu_din;
            end else if (new_vld) begin
                do_v    = 1'b1;
                do_wr   = bus.io_wr;
                do_port = bus.port;
                do_din  = bus.cpu_din;
            end
        end else if (new_vld) begin
            hold_v_d    = 1'b1;
            hold_wr_d   = bus.io_wr;
            hold_port_d = bus.port;
            hold_din_d  = bus.cpu_din;
        end

        if (do_v) begin
            if (do_wr && do_port) begin
                if (ctrl_q == ST_FIRST) begin
                    latch_d = do_din;
                    ctrl_d  = ST_SECOND;
                end else begin
                    ctrl_d = ST_FIRST;
                    if (do_din[7]) begin
                        regs_d[do_din[2:0]] = latch_q;
                    end else begin
                        addr_d = {do_din[5:0], latch_q};
                        if (!do_din[6]) begin
                            vga_addr_d = {do_din[5:0], latch_q};
                            vga_rd_d   = 1'b1;
                            pf_d       = PF_RD;
                        end
                    end
                end
            end else if (do_wr) begin
                ctrl_d     = ST_FIRST;
                vga_din_d  = do_din;
                vga_addr_d = addr_q;
                vga_wr_d   = 1'b1;
                read_buf_d = do_din;
                addr_d     = addr_q + 14'd1;
            end else if (!do_port) begin
                ctrl_d     = ST_FIRST;
                cpu_dout_d = read_buf_q;
                vga_addr_d = addr_q;
                vga_rd_d   = 1'b1;
                pf_d       = PF_RD;
            end else begin
                // Flags clear on read unless a new event lands in the same cycle.
                ctrl_d     = ST_FIRST;
                cpu_dout_d = {f_q, fs_q, c_q, s5_q};
                f_d        = f_set;
                c_d        = sprite_collision;
                fs_d       = too_many_sprites;
            end
        end
    end

    always_comb begin
        if (regs_q[1][4])      mode = 2'd0;
        else if (regs_q[0][1]) mode = 2'd2;
        else if (regs_q[1][3]) mode = 2'd3;
        else                   mode = 2'd1;
    end

    assign mode2 = (mode == 2'd2);

    assign video_on                  = regs_q[1][6];
    assign vert_retrace_int          = regs_q[1][5];
    assign sprite_large              = regs_q[1][1];
    assign sprite_enlarged           = regs_q[1][0];
    assign name_table_addr           = {regs_q[2][3:0], 10'b0};
    assign color_table_addr          = mode2 ? {regs_q[3][7], 13'b0} : {regs_q[3], 6'b0};
    assign font_addr                 = mode2 ? {regs_q[4][2], 13'b0} : {regs_q[4][2:0], 11'b0};
    assign sprite_attr_addr          = {regs_q[5][6:0], 7'b0};
    assign sprite_pattern_table_addr = {regs_q[6][2:0], 11'b0};
    assign text_color                = regs_q[7][7:4];
    assign back_color                = regs_q[7][3:0];

    assign bus.cpu_dout = cpu_dout_q;
    assign bus.vga_addr = vga_addr_q;
    assign bus.vga_din  = vga_din_q;
    assign bus.vga_wr   = vga_wr_q;
    assign bus.vga_rd   = vga_rd_q;

endmodule
`default_nettype wire
